// File: rtl/program_sequencer_dbg.sv
// Program sequencer with debug control for the 8-bit nanoprocessor core.
// Owns the program counter, resolves jumps into the program-memory address,
// and gates datapath execution through a halt / single-step / breakpoint FSM.
module program_sequencer_dbg #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            jmp,
    input  logic            jmp_nz,
    input  logic            dont_jmp,
    input  logic [3:0]      ir_nibble,
    input  logic            halt_req,
    input  logic            run,
    input  logic            step,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    output logic [PC_W-1:0] pm_addr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] from_PS,
    output logic            core_en,
    output logic            halted,
    output logic [15:0]     instr_count
);

    typedef enum logic [1:0] {StBoot, StRun, StHalted} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic            bp_skip_q;
    logic            run_q;
    logic            step_q;
    logic [15:0]     cnt_q;

    logic            run_p;
    logic            step_p;
    logic            take_jmp;
    logic            hit;
    logic [PC_W-1:0] exec_target;

    assign run_p    = run & ~run_q;
    assign step_p   = step & ~step_q;
    assign take_jmp = jmp | (jmp_nz & ~dont_jmp);
    // bp_skip lets the instruction at the breakpoint run once after a resume
    assign hit      = halt_req | (bp_en & (pc_q == bp_addr) & ~bp_skip_q);

    // Address of the next instruction when the current one executes
    always_comb begin
        exec_target = pc_q + 1'b1;
        if (take_jmp) begin
            exec_target = {pc_q[PC_W-1:4], ir_nibble};
        end
    end

    // Next-state, fetch address and execute enable
    always_comb begin
        state_d = state_q;
        pm_addr = pc_q;
        core_en = 1'b0;
        unique case (state_q)
            StBoot: begin
                pm_addr = '0;
                state_d = halt_req ? StHalted : StRun;
            end
            StRun: begin
                if (hit) begin
                    state_d = StHalted;
                end else begin
                    core_en = 1'b1;
                    pm_addr = exec_target;
                end
            end
            StHalted: begin
                if (run_p) begin
                    core_en = 1'b1;
                    pm_addr = exec_target;
                    state_d = StRun;
                end else if (step_p) begin
                    core_en = 1'b1;
                    pm_addr = exec_target;
                end
            end
            default: begin
                state_d = StBoot;
                pm_addr = '0;
            end
        endcase
    end

    // State, program counter, edge detectors, breakpoint skip and counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StBoot;
            pc_q      <= '0;
            bp_skip_q <= 1'b0;
            run_q     <= 1'b0;
            step_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pm_addr;
            run_q   <= run;
            step_q  <= step;
            if (core_en) begin
                bp_skip_q <= (state_q == StHalted);
                if (cnt_q != 16'hFFFF) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

    assign pc          = pc_q;
    assign from_PS     = pc_q;
    assign halted      = (state_q == StHalted);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_program_sequencer_dbg.sv
// Directed self-checking bench for program_sequencer_dbg.
module tb_program_sequencer_dbg;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        jmp = 1'b0, jmp_nz = 1'b0, dont_jmp = 1'b0;
    logic [3:0]  ir_nibble = 4'h0;
    logic        halt_req = 1'b0, run = 1'b0, step = 1'b0, bp_en = 1'b0;
    logic [7:0]  bp_addr = 8'h00;
    logic [7:0]  pm_addr, pc, from_PS;
    logic        core_en, halted;
    logic [15:0] instr_count;

    int nvec = 0;
    int nerr = 0;
    logic [15:0] cnt_save;

    always #5 clk = ~clk;

    program_sequencer_dbg #(.PC_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .dont_jmp    (dont_jmp),
        .ir_nibble   (ir_nibble),
        .halt_req    (halt_req),
        .run         (run),
        .step        (step),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pm_addr     (pm_addr),
        .pc          (pc),
        .from_PS     (from_PS),
        .core_en     (core_en),
        .halted      (halted),
        .instr_count (instr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled well clear of the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pc(input logic [7:0] a);
        for (int i = 0; i < 400; i++) begin
            if (pc == a) return;
            tick();
        end
        check("wait_pc timeout", {24'h0, pc}, {24'h0, a});
    endtask

    task automatic do_reset(input logic bpe, input logic [7:0] bpa);
        jmp = 0; jmp_nz = 0; dont_jmp = 0; ir_nibble = 0;
        halt_req = 0; run = 0; step = 0;
        bp_en = bpe; bp_addr = bpa;
        reset_n = 0;
        tick();
        check("rst pm_addr", {24'h0, pm_addr}, 32'h0);
        check("rst core_en", {31'h0, core_en}, 32'h0);
        check("rst count", {16'h0, instr_count}, 32'h0);
        check("rst halted", {31'h0, halted}, 32'h0);
        reset_n = 1;
        #1;
        check("boot core_en", {31'h0, core_en}, 32'h0);
        check("boot pm_addr", {24'h0, pm_addr}, 32'h0);
        tick();
        check("run0 pc", {24'h0, pc}, 32'h0);
        check("run0 core_en", {31'h0, core_en}, 32'h1);
        check("run0 pm_addr", {24'h0, pm_addr}, 32'h1);
    endtask

    initial begin
        // 1. reset / boot
        do_reset(1'b0, 8'h00);
        check("from_PS", {24'h0, from_PS}, 32'h0);

        // 2. jumps and wrap
        wait_pc(8'h35);
        jmp = 1; ir_nibble = 4'hA; #1;
        check("jmp target", {24'h0, pm_addr}, 32'h3A);
        jmp = 0; jmp_nz = 1; dont_jmp = 1; #1;
        check("jnz not taken", {24'h0, pm_addr}, 32'h36);
        dont_jmp = 0; #1;
        check("jnz taken", {24'h0, pm_addr}, 32'h3A);
        tick();
        jmp_nz = 0;
        check("jmp pc", {24'h0, pc}, 32'h3A);
        check("jmp from_PS", {24'h0, from_PS}, 32'h3A);
        wait_pc(8'hFF);
        #1;
        check("wrap pm_addr", {24'h0, pm_addr}, 32'h0);
        tick();
        check("wrap pc", {24'h0, pc}, 32'h0);

        // 3. breakpoint and resume
        do_reset(1'b1, 8'h05);
        wait_pc(8'h05);
        check("bp core_en", {31'h0, core_en}, 32'h0);
        check("bp pm_addr", {24'h0, pm_addr}, 32'h5);
        check("bp not yet halted", {31'h0, halted}, 32'h0);
        tick();
        check("bp halted", {31'h0, halted}, 32'h1);
        check("bp count", {16'h0, instr_count}, 32'h5);
        check("bp pc", {24'h0, pc}, 32'h5);
        run = 1; #1;
        check("resume core_en", {31'h0, core_en}, 32'h1);
        check("resume pm_addr", {24'h0, pm_addr}, 32'h6);
        tick();
        run = 0;
        check("resume pc6", {24'h0, pc}, 32'h6);
        check("resume running", {31'h0, halted}, 32'h0);
        tick();
        check("resume pc7", {24'h0, pc}, 32'h7);

        // 4. single step
        do_reset(1'b1, 8'h05);
        wait_pc(8'h05);
        tick();
        check("step halted", {31'h0, halted}, 32'h1);
        step = 1; #1;
        check("step core_en", {31'h0, core_en}, 32'h1);
        tick();
        check("step held core_en", {31'h0, core_en}, 32'h0);
        tick();
        tick();
        step = 0;
        check("step pc", {24'h0, pc}, 32'h6);
        check("step still halted", {31'h0, halted}, 32'h1);
        check("step count", {16'h0, instr_count}, 32'h6);
        tick();
        run = 1; step = 1;
        tick();
        run = 0; step = 0;
        check("run+step halted", {31'h0, halted}, 32'h0);
        check("run+step pc", {24'h0, pc}, 32'h7);

        // 5. halt_req behaviour
        do_reset(1'b0, 8'h00);
        wait_pc(8'h20);
        halt_req = 1; #1;
        check("hreq core_en", {31'h0, core_en}, 32'h0);
        check("hreq pm_addr", {24'h0, pm_addr}, 32'h20);
        tick();
        halt_req = 0;
        check("hreq halted", {31'h0, halted}, 32'h1);
        check("hreq pc", {24'h0, pc}, 32'h20);
        run = 1; #1;
        check("hreq resume addr", {24'h0, pm_addr}, 32'h21);
        tick();
        run = 0;
        check("hreq resumed pc", {24'h0, pc}, 32'h21);
        check("hreq resumed", {31'h0, halted}, 32'h0);
        tick();
        halt_req = 1; #1;
        check("hreq2 core_en", {31'h0, core_en}, 32'h0);
        tick();
        check("hreq2 halted", {31'h0, halted}, 32'h1);
        check("hreq2 pc", {24'h0, pc}, 32'h22);
        cnt_save = instr_count;
        run = 1; #1;
        check("hreq2 one exec", {31'h0, core_en}, 32'h1);
        tick();
        run = 0;
        check("hreq2 rehit core_en", {31'h0, core_en}, 32'h0);
        tick();
        check("hreq2 rehalted", {31'h0, halted}, 32'h1);
        check("hreq2 pc after", {24'h0, pc}, 32'h23);
        check("hreq2 count", {16'h0, instr_count}, {16'h0, cnt_save + 16'd1});
        halt_req = 0;

        // 6. reset while halted
        #1 reset_n = 0;
        #1;
        check("async rst pc", {24'h0, pc}, 32'h0);
        check("async rst halted", {31'h0, halted}, 32'h0);
        check("async rst core_en", {31'h0, core_en}, 32'h0);
        check("async rst count", {16'h0, instr_count}, 32'h0);
        do_reset(1'b0, 8'h00);

        // counter saturation: after boot, count equals cycles spent running
        for (int i = 0; i < 65535; i++) tick();
        check("count at max", {16'h0, instr_count}, 32'hFFFF);
        for (int i = 0; i < 4465; i++) tick();
        check("count saturated", {16'h0, instr_count}, 32'hFFFF);
        check("still running", {31'h0, core_en}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
